// File: rtl/thread_fetch_scheduler.sv
// thread_fetch_scheduler
// Per-cycle round-robin thread picker for the 4-thread fetch stage. A thread
// is skipped while it waits on an I-cache fill, while it serves a mispredict
// flush penalty, or while it is disabled. Events seen in a cycle already
// influence the pick registered at the end of that same cycle.

module thread_fetch_scheduler #(
   parameter int FLUSH_PENALTY = 3,
   parameter int CNT_WIDTH     = 3
) (
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic       i_Stall,
   input  logic [3:0] i_thread_enable,
   input  logic       i_miss_valid,
   input  logic [1:0] i_miss_thread,
   input  logic       i_fill_valid,
   input  logic [1:0] i_fill_thread,
   input  logic       i_flush_valid,
   input  logic [1:0] i_flush_thread,
   output logic [1:0] o_thread_choice,
   output logic       o_fetch_valid,
   output logic [3:0] o_blocked
);

   localparam logic [CNT_WIDTH-1:0] PENALTY_LOAD = CNT_WIDTH'(FLUSH_PENALTY);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO     = '0;

   logic [3:0]           r_blocked;
   logic [CNT_WIDTH-1:0] r_pcnt [4];
   logic [1:0]           r_last_ptr;
   logic [1:0]           r_thread_choice;
   logic                 r_fetch_valid;

   logic [3:0]           w_blocked_next;
   logic [CNT_WIDTH-1:0] w_pcnt_next [4];
   logic [3:0]           w_eligible;
   logic [1:0]           w_pick;
   logic                 w_any_eligible;

   // Next miss-block state: a miss wins over a same-cycle fill for the same thread.
   always_comb begin
      w_blocked_next = r_blocked;
      for (int t = 0; t < 4; t++) begin
         if (i_miss_valid && (i_miss_thread == 2'(t))) begin
            w_blocked_next[t] = 1'b1;
         end else if (i_fill_valid && (i_fill_thread == 2'(t))) begin
            w_blocked_next[t] = 1'b0;
         end
      end
   end

   // Next penalty counters: a flush (re)loads the full penalty, otherwise count down to zero.
   always_comb begin
      for (int t = 0; t < 4; t++) begin
         w_pcnt_next[t] = CNT_ZERO;
         if (i_flush_valid && (i_flush_thread == 2'(t))) begin
            w_pcnt_next[t] = PENALTY_LOAD;
         end else if (r_pcnt[t] != CNT_ZERO) begin
            w_pcnt_next[t] = r_pcnt[t] - CNT_ONE;
         end
      end
   end

   // Eligibility uses the next-state view so this cycle's events count immediately.
   always_comb begin
      w_eligible = '0;
      for (int t = 0; t < 4; t++) begin
         w_eligible[t] = i_thread_enable[t] & ~w_blocked_next[t] &
                         (w_pcnt_next[t] == CNT_ZERO);
      end
   end

   // Round-robin scan starting just after the last granted thread, wrapping mod 4.
   always_comb begin
      logic [1:0] idx;
      w_pick         = r_last_ptr;
      w_any_eligible = 1'b0;
      idx            = r_last_ptr;
      for (int i = 1; i <= 4; i++) begin
         idx = r_last_ptr + 2'(i);
         if (!w_any_eligible && w_eligible[idx]) begin
            w_pick         = idx;
            w_any_eligible = 1'b1;
         end
      end
   end

   // State update: block flags and penalties always advance; the grant only moves when not stalled.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_blocked       <= '0;
         for (int t = 0; t < 4; t++) begin
            r_pcnt[t] <= CNT_ZERO;
         end
         r_last_ptr      <= 2'd3;
         r_thread_choice <= 2'd0;
         r_fetch_valid   <= 1'b0;
      end else begin
         r_blocked <= w_blocked_next;
         for (int t = 0; t < 4; t++) begin
            r_pcnt[t] <= w_pcnt_next[t];
         end
         if (!i_Stall) begin
            if (w_any_eligible) begin
               r_thread_choice <= w_pick;
               r_last_ptr      <= w_pick;
               r_fetch_valid   <= 1'b1;
            end else begin
               r_fetch_valid   <= 1'b0;
            end
         end
      end
   end

   assign o_thread_choice = r_thread_choice;
   assign o_fetch_valid   = r_fetch_valid;
   assign o_blocked       = r_blocked;

endmodule

// File: tb/tb_thread_fetch_scheduler.sv
// Scoreboard bench for thread_fetch_scheduler. Each stimulus cycle pushes the
// hand-derived register contents expected right after its clock edge; a
// separate monitor pops one entry per edge and compares.

module tb_thread_fetch_scheduler;

   typedef struct {
      logic [1:0] choice;
      logic       valid;
      logic [3:0] blocked;
      string      name;
   } expect_t;

   logic       i_Clk = 1'b0;
   logic       i_Reset;
   logic       i_Stall;
   logic [3:0] i_thread_enable;
   logic       i_miss_valid;
   logic [1:0] i_miss_thread;
   logic       i_fill_valid;
   logic [1:0] i_fill_thread;
   logic       i_flush_valid;
   logic [1:0] i_flush_thread;
   logic [1:0] o_thread_choice;
   logic       o_fetch_valid;
   logic [3:0] o_blocked;

   expect_t expQueue[$];
   int      checkCount = 0;
   int      failCount  = 0;

   thread_fetch_scheduler #(.FLUSH_PENALTY(3), .CNT_WIDTH(3)) dut (
      .i_Clk           (i_Clk),
      .i_Reset         (i_Reset),
      .i_Stall         (i_Stall),
      .i_thread_enable (i_thread_enable),
      .i_miss_valid    (i_miss_valid),
      .i_miss_thread   (i_miss_thread),
      .i_fill_valid    (i_fill_valid),
      .i_fill_thread   (i_fill_thread),
      .i_flush_valid   (i_flush_valid),
      .i_flush_thread  (i_flush_thread),
      .o_thread_choice (o_thread_choice),
      .o_fetch_valid   (o_fetch_valid),
      .o_blocked       (o_blocked)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 i_Clk = ~i_Clk;

   // Compare one expected entry against the registered outputs.
   task automatic checkOutput(input expect_t e);
      checkCount++;
      if (o_thread_choice !== e.choice) begin
         failCount++;
         $display("[TB] FAIL %s choice: got %0d want %0d", e.name, o_thread_choice, e.choice);
      end
      checkCount++;
      if (o_fetch_valid !== e.valid) begin
         failCount++;
         $display("[TB] FAIL %s valid: got %0b want %0b", e.name, o_fetch_valid, e.valid);
      end
      checkCount++;
      if (o_blocked !== e.blocked) begin
         failCount++;
         $display("[TB] FAIL %s blocked: got %b want %b", e.name, o_blocked, e.blocked);
      end
   endtask

   // Monitor: after every rising edge, pop the entry for that edge and check it.
   initial begin
      expect_t e;
      forever begin
         @(posedge i_Clk);
         #3;
         if (expQueue.size() > 0) begin
            e = expQueue.pop_front();
            checkOutput(e);
         end
      end
   end

   // Push the expectation for the coming edge, clock it, then drop one-shot events.
   task automatic applyStimulus(input logic [1:0] choice, input logic valid,
                                input logic [3:0] blocked, input string name);
      expect_t e;
      e.choice  = choice;
      e.valid   = valid;
      e.blocked = blocked;
      e.name    = name;
      expQueue.push_back(e);
      @(posedge i_Clk);
      #1;
      i_Reset       = 1'b0;
      i_miss_valid  = 1'b0;
      i_fill_valid  = 1'b0;
      i_flush_valid = 1'b0;
   endtask

   // Directed sequence; comments track last granted thread (lp).
   initial begin
      int waitCycles;
      i_Reset = 1'b1; i_Stall = 1'b0; i_thread_enable = 4'hF;
      i_miss_valid = 1'b0; i_miss_thread = 2'd0;
      i_fill_valid = 1'b0; i_fill_thread = 2'd0;
      i_flush_valid = 1'b0; i_flush_thread = 2'd0;

      applyStimulus(2'd0, 1'b0, 4'h0, "reset0");
      i_Reset = 1'b1;
      applyStimulus(2'd0, 1'b0, 4'h0, "reset1");

      // All enabled round robin from thread 0; a stray fill for unblocked thread 2 is ignored.
      applyStimulus(2'd0, 1'b1, 4'h0, "rr0");
      applyStimulus(2'd1, 1'b1, 4'h0, "rr1");
      i_fill_valid = 1'b1; i_fill_thread = 2'd2;
      applyStimulus(2'd2, 1'b1, 4'h0, "rr2_strayfill");
      applyStimulus(2'd3, 1'b1, 4'h0, "rr3");
      applyStimulus(2'd0, 1'b1, 4'h0, "rr4");
      applyStimulus(2'd1, 1'b1, 4'h0, "rr5");          // lp=1

      // Only threads 0 and 2 enabled.
      i_thread_enable = 4'b0101;
      applyStimulus(2'd2, 1'b1, 4'h0, "en5_a");
      applyStimulus(2'd0, 1'b1, 4'h0, "en5_b");
      applyStimulus(2'd2, 1'b1, 4'h0, "en5_c");
      applyStimulus(2'd0, 1'b1, 4'h0, "en5_d");        // lp=0
      i_thread_enable = 4'b0100;
      applyStimulus(2'd2, 1'b1, 4'h0, "en4_a");
      applyStimulus(2'd2, 1'b1, 4'h0, "en4_b");
      applyStimulus(2'd2, 1'b1, 4'h0, "en4_c");        // lp=2

      // Miss on thread 1 while choice is 0.
      i_thread_enable = 4'hF;
      applyStimulus(2'd3, 1'b1, 4'h0, "pre_miss_a");
      applyStimulus(2'd0, 1'b1, 4'h0, "pre_miss_b");   // lp=0
      i_miss_valid = 1'b1; i_miss_thread = 2'd1;
      applyStimulus(2'd2, 1'b1, 4'b0010, "miss1_a");
      applyStimulus(2'd3, 1'b1, 4'b0010, "miss1_b");
      applyStimulus(2'd0, 1'b1, 4'b0010, "miss1_c");
      applyStimulus(2'd2, 1'b1, 4'b0010, "miss1_d");   // lp=2
      i_miss_valid = 1'b1; i_miss_thread = 2'd1;
      i_fill_valid = 1'b1; i_fill_thread = 2'd1;
      applyStimulus(2'd3, 1'b1, 4'b0010, "missfill_same");
      applyStimulus(2'd0, 1'b1, 4'b0010, "still_blocked"); // lp=0
      i_fill_valid = 1'b1; i_fill_thread = 2'd1;
      applyStimulus(2'd1, 1'b1, 4'b0000, "fill1");     // lp=1

      // Flush penalty with threads 0 and 2.
      i_thread_enable = 4'b0101;
      applyStimulus(2'd2, 1'b1, 4'h0, "pre_flush_a");
      applyStimulus(2'd0, 1'b1, 4'h0, "pre_flush_b");  // lp=0
      i_flush_valid = 1'b1; i_flush_thread = 2'd2;
      applyStimulus(2'd0, 1'b1, 4'h0, "flush_k");
      applyStimulus(2'd0, 1'b1, 4'h0, "flush_k1");
      applyStimulus(2'd0, 1'b1, 4'h0, "flush_k2");
      applyStimulus(2'd2, 1'b1, 4'h0, "flush_k3");
      applyStimulus(2'd0, 1'b1, 4'h0, "flush_after");  // lp=0
      i_flush_valid = 1'b1; i_flush_thread = 2'd2;
      applyStimulus(2'd0, 1'b1, 4'h0, "reflush_m");
      i_flush_valid = 1'b1; i_flush_thread = 2'd2;
      applyStimulus(2'd0, 1'b1, 4'h0, "reflush_m1");
      applyStimulus(2'd0, 1'b1, 4'h0, "reflush_m2");
      applyStimulus(2'd0, 1'b1, 4'h0, "reflush_m3");
      applyStimulus(2'd2, 1'b1, 4'h0, "reflush_m4");   // lp=2

      // Miss every thread, then recover with fills.
      i_thread_enable = 4'hF;
      i_miss_valid = 1'b1; i_miss_thread = 2'd0;
      applyStimulus(2'd3, 1'b1, 4'b0001, "missall_0");
      i_miss_valid = 1'b1; i_miss_thread = 2'd1;
      applyStimulus(2'd2, 1'b1, 4'b0011, "missall_1");
      i_miss_valid = 1'b1; i_miss_thread = 2'd2;
      applyStimulus(2'd3, 1'b1, 4'b0111, "missall_2");
      i_miss_valid = 1'b1; i_miss_thread = 2'd3;
      applyStimulus(2'd3, 1'b0, 4'b1111, "missall_3");
      applyStimulus(2'd3, 1'b0, 4'b1111, "none_eligible");
      i_fill_valid = 1'b1; i_fill_thread = 2'd3;
      applyStimulus(2'd3, 1'b1, 4'b0111, "fill3");     // lp=3
      i_fill_valid = 1'b1; i_fill_thread = 2'd0;
      applyStimulus(2'd0, 1'b1, 4'b0110, "fill0");
      i_fill_valid = 1'b1; i_fill_thread = 2'd1;
      applyStimulus(2'd1, 1'b1, 4'b0100, "fill1b");
      i_fill_valid = 1'b1; i_fill_thread = 2'd2;
      applyStimulus(2'd2, 1'b1, 4'b0000, "fill2");     // lp=2

      // Stall across a flush penalty; thread 3 becomes eligible right at unstall.
      i_thread_enable = 4'b1001;
      i_flush_valid = 1'b1; i_flush_thread = 2'd3;
      applyStimulus(2'd0, 1'b1, 4'h0, "stflush_k");    // lp=0
      i_Stall = 1'b1;
      applyStimulus(2'd0, 1'b1, 4'h0, "stall1");
      i_miss_valid = 1'b1; i_miss_thread = 2'd1;
      applyStimulus(2'd0, 1'b1, 4'b0010, "stall2_miss");
      applyStimulus(2'd0, 1'b1, 4'b0010, "stall3");
      applyStimulus(2'd0, 1'b1, 4'b0010, "stall4");
      i_Stall = 1'b0;
      applyStimulus(2'd3, 1'b1, 4'b0010, "unstall");   // lp=3

      // Reset overrides simultaneous miss and flush, then round robin restarts at 0.
      i_thread_enable = 4'hF;
      i_Reset = 1'b1;
      i_miss_valid = 1'b1; i_miss_thread = 2'd2;
      i_flush_valid = 1'b1; i_flush_thread = 2'd0;
      applyStimulus(2'd0, 1'b0, 4'h0, "midreset");
      applyStimulus(2'd0, 1'b1, 4'h0, "post_rst0");
      applyStimulus(2'd1, 1'b1, 4'h0, "post_rst1");
      applyStimulus(2'd2, 1'b1, 4'h0, "post_rst2");

      waitCycles = 0;
      while (expQueue.size() > 0 && waitCycles < 10) begin
         @(posedge i_Clk);
         waitCycles++;
      end
      #5;
      if (expQueue.size() > 0) begin
         failCount++;
         $display("[TB] FAIL drain: pending %0d want 0", expQueue.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
